run_monitor: RTL

Observation block that sits downstream of the single-cycle CPU core in simulation and FPGA bring-up builds. It snoops the core's PC and register-file write port and detects program completion, i.e. a jump-to-self halt loop. It applies a cycle-count watchdog and latches the final value written to a selected architectural register. Benches and the board harness read done/result from this block instead of waiting a fixed delay and probing register-file internals.

---
 rtl/run_monitor_pkg.sv | 17 +
 rtl/run_monitor_if.sv | 46 ++++
 rtl/rm_sat_counter.sv | 30 +++
 rtl/run_monitor.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/run_monitor_pkg.sv
// run_monitor_pkg: shared types and constants for the run_monitor block.
//   rm_state_e : 2-bit monitor state (IDLE, RUN, HALTED, TIMEOUT)
//   REG_ZERO   : architectural $zero register number (never a qualifying write)
//   HIST_DEPTH : depth of the optional write history (RUN_MONITOR_HIST_EN)
package run_monitor_pkg;

  typedef enum logic [1:0] {
    RM_IDLE    = 2'd0,
    RM_RUN     = 2'd1,
    RM_HALTED  = 2'd2,
    RM_TIMEOUT = 2'd3
  } rm_state_e;

  localparam logic [4:0] REG_ZERO   = 5'd0;
  localparam int         HIST_DEPTH = 4;

endpackage

// File: rtl/run_monitor_if.sv
// run_monitor_if: snoop/result bundle between the CPU core harness (master)
// and the run monitor (slave).
//   master drives : start, result_sel, pc, rf_we, rf_waddr, rf_wdata [, hist_idx]
//   slave drives  : busy, done, timeout, result, result_valid,
//                   cycle_count, write_count [, hist_data]
// Optional macro RUN_MONITOR_HIST_EN adds hist_idx (2b) / hist_data (37b).
interface run_monitor_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic [4:0]       result_sel;
  logic [31:0]      pc;
  logic             rf_we;
  logic [4:0]       rf_waddr;
  logic [31:0]      rf_wdata;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [31:0]      result;
  logic             result_valid;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] write_count;
`ifdef RUN_MONITOR_HIST_EN
  logic [1:0]       hist_idx;
  logic [36:0]      hist_data;
`endif

  modport master (
    output start, result_sel, pc, rf_we, rf_waddr, rf_wdata,
`ifdef RUN_MONITOR_HIST_EN
    output hist_idx,
    input  hist_data,
`endif
    input  busy, done, timeout, result, result_valid, cycle_count, write_count
  );

  modport slave (
    input  start, result_sel, pc, rf_we, rf_waddr, rf_wdata,
`ifdef RUN_MONITOR_HIST_EN
    input  hist_idx,
    output hist_data,
`endif
    output busy, done, timeout, result, result_valid, cycle_count, write_count
  );

endinterface

// File: rtl/rm_sat_counter.sv
// rm_sat_counter: width-parameterised up-counter that sticks at all-ones.
//   clk, rst_n : clock, asynchronous active-low reset (count -> 0)
//   i_clr      : synchronous clear, has priority over i_inc
//   i_inc      : increment request
//   o_cnt      : current count
module rm_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/run_monitor.sv
// run_monitor: watches the core PC and register-file write port, declares
// halt on a jump-to-self loop, applies a cycle watchdog and captures the
// last value written to a selected register.
//   clk, rst_n : core clock, asynchronous active-low reset
//   bus        : run_monitor_if.slave (start/result_sel/pc/rf_* in,
//                busy/done/timeout/result/result_valid/cycle_count/write_count out)
// Parameters: HALT_CYCLES (>=2), TIMEOUT_CYCLES (0 = no watchdog), CNT_W.
// Optional macro RUN_MONITOR_HIST_EN: 4-entry history of qualifying writes,
// read combinationally through hist_idx (0 = newest) / hist_data.
module run_monitor
  import run_monitor_pkg::*;
#(
  parameter int HALT_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_W          = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  run_monitor_if.slave bus
);

  // stable_cnt only has to reach HALT_CYCLES-1; one extra bit keeps it clear of saturation.
  localparam int               STB_W    = $clog2(HALT_CYCLES) + 1;
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(HALT_CYCLES - 2);
  localparam bit               TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TMO_LAST = TMO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  rm_state_e        r_state;
  logic [4:0]       r_sel_q;
  logic [31:0]      r_pc_prev;
  logic [31:0]      r_result;
  logic             r_result_valid;

  logic             w_run;
  logic             w_pc_same;
  logic             w_qual;
  logic             w_halt;
  logic             w_tmo;
  logic [STB_W-1:0] w_stable_cnt;
  logic [CNT_W-1:0] w_cycle_cnt;
  logic [CNT_W-1:0] w_write_cnt;

  assign w_run     = (r_state == RM_RUN);
  assign w_pc_same = (bus.pc == r_pc_prev);
  assign w_qual    = w_run && bus.rf_we && (bus.rf_waddr != REG_ZERO);
  // Halt fires on the edge where stable_cnt would reach HALT_CYCLES-1, so done
  // rises exactly HALT_CYCLES cycles after the loop PC first appears.
  assign w_halt    = w_run && w_pc_same && (w_stable_cnt == STB_LAST);
  assign w_tmo     = TMO_EN && w_run && (w_cycle_cnt == TMO_LAST);

  // A start pulse always wins: it restarts from any state, RUN included.
  rm_sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (bus.start),
    .i_inc (w_run),
    .o_cnt (w_cycle_cnt)
  );

  rm_sat_counter #(.W(CNT_W)) u_write_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (bus.start),
    .i_inc (w_qual),
    .o_cnt (w_write_cnt)
  );

  rm_sat_counter #(.W(STB_W)) u_stable_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (bus.start || (w_run && !w_pc_same)),
    .i_inc (w_run && w_pc_same),
    .o_cnt (w_stable_cnt)
  );

  // Halt is checked before the watchdog so a simultaneous hit reports done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RM_IDLE;
    end else if (bus.start) begin
      r_state <= RM_RUN;
    end else if (w_halt) begin
      r_state <= RM_HALTED;
    end else if (w_tmo) begin
      r_state <= RM_TIMEOUT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_q        <= REG_ZERO;
      r_pc_prev      <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
    end else begin
      if (bus.start) begin
        r_sel_q <= bus.result_sel;
      end
      if (bus.start || w_run) begin
        r_pc_prev <= bus.pc;
      end
      if (bus.start) begin
        r_result       <= '0;
        r_result_valid <= 1'b0;
      end else if (w_qual && (bus.rf_waddr == r_sel_q)) begin
        r_result       <= bus.rf_wdata;
        r_result_valid <= 1'b1;
      end
    end
  end

  assign bus.busy         = (r_state == RM_RUN);
  assign bus.done         = (r_state == RM_HALTED);
  assign bus.timeout      = (r_state == RM_TIMEOUT);
  assign bus.result       = r_result;
  assign bus.result_valid = r_result_valid;
  assign bus.cycle_count  = w_cycle_cnt;
  assign bus.write_count  = w_write_cnt;

`ifdef RUN_MONITOR_HIST_EN
  logic [36:0] r_hist [HIST_DEPTH];
  logic [1:0]  r_wptr;
  logic [1:0]  w_rd_idx;

  // Entries are wiped on start too, so slots not yet written in this run read 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= 2'd0;
      for (int i = 0; i < HIST_DEPTH; i++) r_hist[i] <= '0;
    end else if (bus.start) begin
      r_wptr <= 2'd0;
      for (int i = 0; i < HIST_DEPTH; i++) r_hist[i] <= '0;
    end else if (w_qual) begin
      r_hist[r_wptr] <= {bus.rf_waddr, bus.rf_wdata};
      r_wptr         <= r_wptr + 2'd1;
    end
  end

  // r_wptr points at the next free slot; the newest entry sits one behind it.
  assign w_rd_idx      = r_wptr - 2'd1 - bus.hist_idx;
  assign bus.hist_data = r_hist[w_rd_idx];
`endif

endmodule
